mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the ALU. Consumes Alu_result as the effective byte address and read_data_2 as store data.
- Drives the synchronous data RAM with 1-cycle read latency and a small MMIO block: LED output register and synchronized switch input.
- Returns sign- or zero-extended load data to register write-back.
- Asserts stall while a RAM load is in flight; the core holds PC and all control signals while stall=1.

Parameters:
- RAM_ADDR_W, 14, word-address width of data RAM (64 KiB).
- IO_BASE, 32'hFFFF_FC00, start of MMIO region; address >= IO_BASE selects MMIO.
- LED_OFS, 10'h060, byte offset of LED register within MMIO.
- SW_OFS, 10'h070, byte offset of switch register within MMIO.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- MemRead  in  1  load instruction in current cycle
- MemWrite  in  1  store instruction in current cycle
- funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- Alu_result  in  32  effective byte address
- read_data_2  in  32  store data, rs2
- mem_rdata  out  32  extended load result to write-back
- stall  out  1  hold PC / pipeline this cycle
- mem_err  out  1  misaligned access or illegal funct3
- ram_addr  out  RAM_ADDR_W  word address, Alu_result[RAM_ADDR_W+1:2]
- ram_wen  out  4  byte write enables
- ram_wdata  out  32  lane-replicated store data
- ram_rdata  in  32  RAM read data, valid 1 cycle after address
- io_sw  in  16  raw switch inputs, asynchronous
- io_led  out  16  LED register

Behaviour:
- Reset (async, rst=1): state=IDLE; mem_rdata=0, stall=0, mem_err=0, ram_wen=0, io_led=0, sync flops=0, rdata_q=0.
- FSM states and transitions:
  - IDLE: if MemRead && !err && RAM region, go to RD_WAIT; otherwise stay in IDLE.
  - RD_WAIT: capture ram_rdata into rdata_q; go to RD_DONE.
  - RD_DONE: go to IDLE unconditionally. MemRead is still high here for the same instruction and must not restart a load.
- Stall:
  - stall = (IDLE && MemRead && !err && RAM region) || RD_WAIT.
  - Stall is 0 in RD_DONE, where the core commits the load.
- Latency:
  - RAM load: 2 stall cycles; data valid in the 3rd cycle.
  - MMIO load, all stores, and errored accesses: 0 stall cycles.
- Alignment:
  - h/hu requires addr[0]=0; w requires addr[1:0]=00.
  - funct3 values 011, 110, 111 are illegal.
  - On error: mem_err=1 (combinational, same cycle), ram_wen=0, no LED update, mem_rdata=0, no stall.
  - mem_err is 0 when neither MemRead nor MemWrite is set.
- Stores (IDLE, MemWrite, !err):
  - sb: ram_wen = 1 << addr[1:0], ram_wdata = {4{rs2[7:0]}}.
  - sh: ram_wen = 0011 or 1100 per addr[1], ram_wdata = {2{rs2[15:0]}}.
  - sw: ram_wen = 1111, ram_wdata = rs2.
  - ram_wen is forced to 0 outside IDLE and for MMIO addresses.
- MMIO:
  - Store to IO_BASE+LED_OFS: io_led <= rs2[15:0] at clock edge. Store size is ignored; the word must be aligned.
  - Load from IO_BASE+SW_OFS: mem_rdata = {16'b0, sw_sync} in the same cycle.
  - Switches pass through a 2-flop synchronizer.
  - Unmapped MMIO load returns 0; unmapped MMIO store is ignored; no mem_err is raised for either.
- Load extension:
  - Selected lane from rdata_q using addr[1:0], which is held stable by the stalled core.
  - lb/lh sign-extend; lbu/lhu zero-extend.
  - mem_rdata=0 when no load is committing.
- Simultaneous MemRead && MemWrite: treated as illegal; mem_err=1, no action.
- rst asserted mid-load: FSM returns to IDLE immediately; stall drops asynchronously.

Decomposition:
- Package mem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - IO_BASE, LED_OFS, SW_OFS;
  - state encoding (IDLE, RD_WAIT, RD_DONE).
- Sub-module load_aligner: combinational lane select and extension (inputs word, addr[1:0], funct3; output 32-bit).

Test Plan:
- sw 0xDEADBEEF at 0x10, then lw 0x10 → ram_wen=1111 in the store cycle; load shows stall=1,1,0 and mem_rdata=0xDEADBEEF in cycle 3.
- sb 0x80 at 0x13, then lb 0x13 / lbu 0x13 → ram_wen=1000; lb returns 0xFFFFFF80, lbu returns 0x00000080.
- sh 0x8001 at 0x22, then lh 0x22 → ram_wen=1100, ram_wdata=0x80018001; lh returns 0xFFFF8001.
- lw at 0x11 and sh at 0x23 → mem_err=1, ram_wen=0, stall=0, mem_rdata=0.
- Store 0x1234ABCD to 0xFFFFFC60 → io_led=0xABCD next edge. With io_sw=0x00F0 for ≥3 cycles, lw 0xFFFFFC70 → 0x000000F0, stall=0.
- Assert rst during RD_WAIT → stall=0, io_led=0, state IDLE. A following lw completes normally with correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size codes, MMIO map and FSM states for the memory access unit.
package mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;
    localparam logic [9:0] LED_OFS = 10'h060;
    localparam logic [9:0] SW_OFS  = 10'h070;
    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    function automatic logic f3_legal(input logic [2:0] f3);
        return f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU;
    endfunction
endpackage

// File: rtl/mem_access_unit_load_aligner.sv
// load_aligner: picks the addressed byte/half lane of a RAM word and sign- or zero-extends it.
module load_aligner
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{addr, 3'b000} +: 8];
    assign h = addr[1] ? word[31:16] : word[15:0];
    always_comb
        data = funct3 == F3_B  ? {{24{b[7]}}, b} :
               funct3 == F3_BU ? {24'b0, b} :
               funct3 == F3_H  ? {{16{h[15]}}, h} :
               funct3 == F3_HU ? {16'b0, h} : word;
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store stage driving a 1-cycle-latency data RAM plus LED/switch MMIO.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int RAM_ADDR_W = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [31:0]           Alu_result,
    input  logic [31:0]           read_data_2,
    output logic [31:0]           mem_rdata,
    output logic                  stall,
    output logic                  mem_err,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [3:0]            ram_wen,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    input  logic [15:0]           io_sw,
    output logic [15:0]           io_led
);
    localparam logic [31:0] LED_ADDR = IO_BASE + {22'b0, LED_OFS};
    localparam logic [31:0] SW_ADDR  = IO_BASE + {22'b0, SW_OFS};
    state_t state, next;
    logic [31:0] rdata_q, ld_word;
    logic [15:0] sw_meta, sw_sync;
    logic io, misal, err, ld_ok, st_ok, rd_ram;
    assign io = Alu_result >= IO_BASE;
    assign misal = (funct3[1:0] == 2'b01 && Alu_result[0]) ||
                   (funct3[1:0] == 2'b10 && Alu_result[1:0] != 2'b00);
    assign err = !rst && (MemRead || MemWrite) &&
                 ((MemRead && MemWrite) || !f3_legal(funct3) || misal);
    assign mem_err = err;
    assign ld_ok = !rst && MemRead && !err;
    assign st_ok = !rst && state == IDLE && MemWrite && !err;
    assign rd_ram = state == IDLE && ld_ok && !io;
    assign stall = rd_ram || state == RD_WAIT;
    assign ram_addr = Alu_result[RAM_ADDR_W+1:2];
    // RD_DONE always returns to IDLE so the still-asserted MemRead cannot relaunch the load
    always_comb
        next = state == IDLE ? (rd_ram ? RD_WAIT : IDLE) :
               state == RD_WAIT ? RD_DONE : IDLE;
    always_comb begin
        ram_wen = !(st_ok && !io) ? 4'b0000 :
                  funct3[1:0] == 2'b00 ? 4'b0001 << Alu_result[1:0] :
                  funct3[1:0] == 2'b01 ? (Alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        ram_wdata = funct3[1:0] == 2'b00 ? {4{read_data_2[7:0]}} :
                    funct3[1:0] == 2'b01 ? {2{read_data_2[15:0]}} : read_data_2;
        mem_rdata = state == RD_DONE && ld_ok ? ld_word :
                    state == IDLE && ld_ok && io && Alu_result == SW_ADDR ? {16'b0, sw_sync} : 32'b0;
    end
    load_aligner u_align (
        .word   (rdata_q),
        .addr   (Alu_result[1:0]),
        .funct3 (funct3),
        .data   (ld_word)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rdata_q <= '0;
            io_led  <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            state   <= next;
            sw_meta <= io_sw;
            sw_sync <= sw_meta;
            if (state == RD_WAIT)
                rdata_q <= ram_rdata;
            if (st_ok && Alu_result == LED_ADDR)
                io_led <= read_data_2[15:0];
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table plus hand-written load/reset sequences against a RAM model.
module tb_mem_access_unit;
    logic        clk, rst, MemRead, MemWrite;
    logic [2:0]  funct3;
    logic [31:0] Alu_result, read_data_2, mem_rdata, ram_wdata, ram_rdata;
    logic        stall, mem_err;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wen;
    logic [15:0] io_sw, io_led;
    logic [31:0] mem [256];
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic        err, stall;
        logic [31:0] rdata;
    } vec_t;
    vec_t v [13];

    mem_access_unit dut (
        .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
        .Alu_result(Alu_result), .read_data_2(read_data_2), .mem_rdata(mem_rdata),
        .stall(stall), .mem_err(mem_err), .ram_addr(ram_addr), .ram_wen(ram_wen),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_sw(io_sw), .io_led(io_led)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_wen[i]) mem[ram_addr[7:0]][8*i +: 8] <= ram_wdata[8*i +: 8];
        ram_rdata <= mem[ram_addr[7:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input int n, input vec_t x);
        MemRead = x.rd; MemWrite = x.wr; funct3 = x.f3; Alu_result = x.addr; read_data_2 = x.wd;
        @(negedge clk);
        chk($sformatf("v%0d mem_err", n), {31'b0, mem_err}, {31'b0, x.err});
        chk($sformatf("v%0d stall", n), {31'b0, stall}, {31'b0, x.stall});
        chk($sformatf("v%0d ram_wen", n), {28'b0, ram_wen}, {28'b0, x.wen});
        chk($sformatf("v%0d mem_rdata", n), mem_rdata, x.rdata);
        if (x.wen != 4'b0000) chk($sformatf("v%0d ram_wdata", n), ram_wdata, x.wdata);
        @(posedge clk); #1;
        MemRead = 0; MemWrite = 0;
    endtask

    task automatic do_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] exp);
        MemRead = 1; MemWrite = 0; funct3 = f3; Alu_result = addr;
        @(negedge clk);
        chk({name, " stall c1"}, {31'b0, stall}, 32'd1);
        chk({name, " rdata c1"}, mem_rdata, 32'h0);
        @(posedge clk); @(negedge clk);
        chk({name, " stall c2"}, {31'b0, stall}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk({name, " stall c3"}, {31'b0, stall}, 32'd0);
        chk({name, " rdata c3"}, mem_rdata, exp);
        @(posedge clk); #1;
        MemRead = 0;
        @(negedge clk);
        chk({name, " idle after"}, {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        //        rd    wr    f3      addr           wd             wen    wdata          err   stall rdata
        v[0]  = '{1'b0, 1'b1, 3'b010, 32'h10,        32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        v[1]  = '{1'b0, 1'b1, 3'b000, 32'h13,        32'h00000080, 4'h8, 32'h80808080, 1'b0, 1'b0, 32'h0};
        v[2]  = '{1'b0, 1'b1, 3'b001, 32'h22,        32'h00008001, 4'hC, 32'h80018001, 1'b0, 1'b0, 32'h0};
        v[3]  = '{1'b1, 1'b0, 3'b010, 32'h11,        32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
        v[4]  = '{1'b0, 1'b1, 3'b001, 32'h23,        32'h00001234, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
        v[5]  = '{1'b1, 1'b0, 3'b011, 32'h10,        32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
        v[6]  = '{1'b1, 1'b1, 3'b010, 32'h10,        32'h11111111, 4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
        v[7]  = '{1'b0, 1'b0, 3'b011, 32'h11,        32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        v[8]  = '{1'b0, 1'b1, 3'b010, 32'hFFFFFC60,  32'h1234ABCD, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        v[9]  = '{1'b0, 1'b1, 3'b000, 32'hFFFFFC64,  32'h00000055, 4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        v[10] = '{1'b1, 1'b0, 3'b010, 32'hFFFFFC70,  32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h000000F0};
        v[11] = '{1'b1, 1'b0, 3'b010, 32'hFFFFFC80,  32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        v[12] = '{1'b1, 1'b0, 3'b010, 32'hFFFFFC71,  32'h0,        4'h0, 32'h0,        1'b1, 1'b0, 32'h0};

        rst = 1; MemRead = 0; MemWrite = 0; funct3 = 0; Alu_result = 0; read_data_2 = 0;
        io_sw = 16'h00F0;
        @(negedge clk);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset mem_err", {31'b0, mem_err}, 32'd0);
        chk("reset ram_wen", {28'b0, ram_wen}, 32'd0);
        chk("reset io_led", {16'b0, io_led}, 32'd0);
        chk("reset mem_rdata", mem_rdata, 32'd0);
        @(posedge clk); #1 rst = 0;
        repeat (3) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) apply(i, v[i]);
        @(negedge clk);
        chk("io_led after stores", {16'b0, io_led}, 32'h0000ABCD);
        @(posedge clk); #1;

        do_load("lw 0x10", 3'b010, 32'h10, 32'h80ADBEEF);
        do_load("lb 0x13", 3'b000, 32'h13, 32'hFFFFFF80);
        do_load("lbu 0x13", 3'b100, 32'h13, 32'h00000080);
        do_load("lb 0x10", 3'b000, 32'h10, 32'hFFFFFFEF);
        do_load("lh 0x22", 3'b001, 32'h22, 32'hFFFF8001);
        do_load("lhu 0x22", 3'b101, 32'h22, 32'h00008001);
        do_load("lw 0x20", 3'b010, 32'h20, 32'h80010000);
        apply(13, '{1'b0, 1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0});
        do_load("lw 0x30", 3'b010, 32'h30, 32'hDEADBEEF);

        MemRead = 1; funct3 = 3'b010; Alu_result = 32'h30;
        @(negedge clk);
        chk("rst-load stall c1", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        chk("rst-load stall RD_WAIT", {31'b0, stall}, 32'd1);
        rst = 1;
        #1;
        chk("rst-load stall dropped", {31'b0, stall}, 32'd0);
        chk("rst-load io_led", {16'b0, io_led}, 32'd0);
        chk("rst-load mem_rdata", mem_rdata, 32'd0);
        MemRead = 0;
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        do_load("lw after rst", 3'b010, 32'h30, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
